spi_slave_xfer: RTL and testbench

Parametrised SPI slave transfer engine. It is the next generation of the fixed 16-bit/128-bit receive-send slave. It supports all four SPI modes, per-frame byte counts up to MAX_BYTES, full-duplex shifting (MOSI and MISO in the same frame) and explicit abort/underrun reporting. It sits between the external SPI pins and the command decoder, in the CLK domain.

---
 rtl/spi_slave_xfer_pkg.sv | 24 ++
 rtl/spi_slave_xfer_if.sv | 43 ++++
 rtl/spi_slave_xfer_edge_sync.sv | 47 ++++
 rtl/spi_slave_xfer.sv | 183 ++++++++++++++++++
 tb/tb_spi_slave_xfer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_xfer_pkg.sv
// Shared types and helpers for the SPI slave transfer engine.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DEFAULT_MAX_BYTES = 16;

  // A byte count of zero or beyond the buffer means "use the whole buffer".
  function automatic int unsigned clamp_bytes(input int unsigned bc,
                                              input int unsigned max_bytes);
    return ((bc == 0) || (bc > max_bytes)) ? max_bytes : bc;
  endfunction

endpackage

// File: rtl/spi_slave_xfer_if.sv
// Pin and command-side bundle of the SPI slave transfer engine.
interface spi_slave_xfer_if #(
  parameter int MAX_BYTES = spi_slave_pkg::DEFAULT_MAX_BYTES
);
  import spi_slave_pkg::*;

  localparam int W    = MAX_BYTES * 8;
  localparam int BC_W = $clog2(MAX_BYTES + 1);

  // Handshake semantics: tx_load is a one-cycle strobe, accepted only while
  // busy is low (and not in the cycle a frame starts); it has no ready.
  // rx_valid, aborted and tx_underrun are one-cycle status strobes with no
  // back-pressure; rx_data is valid with rx_valid and holds until the next.
  logic              SCK;
  logic              MOSI;
  logic              CSEL;
  logic              MISO;
  logic              cpol;
  logic              cpha;
  logic [BC_W-1:0]   byte_count;
  logic [W-1:0]      tx_data;
  logic              tx_load;
  logic              tx_loaded;
  logic              busy;
  logic [W-1:0]      rx_data;
  logic              rx_valid;
  logic              aborted;
  logic              tx_underrun;
  state_t            dbg_state;

  modport slave (
    input  SCK, MOSI, CSEL, cpol, cpha, byte_count, tx_data, tx_load,
    output MISO, tx_loaded, busy, rx_data, rx_valid, aborted, tx_underrun,
           dbg_state
  );

  modport master (
    output SCK, MOSI, CSEL, cpol, cpha, byte_count, tx_data, tx_load,
    input  MISO, tx_loaded, busy, rx_data, rx_valid, aborted, tx_underrun,
           dbg_state
  );

endinterface

// File: rtl/spi_slave_xfer_edge_sync.sv
// Multi-flop synchroniser for an asynchronous pin, with registered level
// and rise/fall pulses that are aligned with each other.
module spi_edge_sync #(
  parameter int   STAGES    = 3,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  // Shift the pin through the chain and compare against the previous level.
  always_comb begin
    sync_d  = {sync_q[STAGES-2:0], d};
    level_d = sync_q[STAGES-1];
    rise_d  = sync_q[STAGES-1] & ~level_q;
    fall_d  = ~sync_q[STAGES-1] & level_q;
  end

  // Reset to the pin's idle level so no edge is reported out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {STAGES{RESET_VAL}};
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_slave_xfer.sv
// SPI slave transfer engine: all four modes, variable byte count,
// full-duplex shifting, abort and underrun reporting.
module spi_slave_xfer
  import spi_slave_pkg::*;
#(
  parameter int MAX_BYTES   = DEFAULT_MAX_BYTES,
  parameter int SYNC_STAGES = 3
) (
  input  logic             CLK,
  input  logic             RST,
  spi_slave_xfer_if.slave  bus
);

  localparam int W  = MAX_BYTES * 8;
  localparam int CW = $clog2(W);

  logic sck_lvl, sck_rise, sck_fall;
  logic csel_lvl, csel_rise, csel_fall;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(CLK), .rst_n(RST), .d(bus.SCK),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_csel_sync (
    .clk(CLK), .rst_n(RST), .d(bus.CSEL),
    .level(csel_lvl), .rise(csel_rise), .fall(csel_fall)
  );

  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;

  state_t          state_q, state_d;
  logic            cpol_q, cpol_d;
  logic            cpha_q, cpha_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [W-1:0]    rx_sh_q, rx_sh_d;
  logic [W-1:0]    tx_sh_q, tx_sh_d;
  logic [W-1:0]    tx_word_q, tx_word_d;
  logic            tx_loaded_q, tx_loaded_d;
  logic [W-1:0]    rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            aborted_q, aborted_d;
  logic            tx_underrun_q, tx_underrun_d;
  logic            miso_q, miso_d;

  logic            sck_edge, lead_ev, trail_ev, sample_ev, shift_ev;
  int unsigned     nbits;
  logic [W-1:0]    aligned;

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Frame sequencing, shifting and status strobes.
  always_comb begin
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
    state_d       = state_q;
    cpol_d        = cpol_q;
    cpha_d        = cpha_q;
    bit_cnt_d     = bit_cnt_q;
    rx_sh_d       = rx_sh_q;
    tx_sh_d       = tx_sh_q;
    tx_word_d     = tx_word_q;
    tx_loaded_d   = tx_loaded_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    aborted_d     = 1'b0;
    tx_underrun_d = 1'b0;
    miso_d        = miso_q;

    // Leading edge leaves the idle level cpol; trailing edge returns to it.
    sck_edge  = sck_rise | sck_fall;
    lead_ev   = sck_edge & (sck_lvl != cpol_q);
    trail_ev  = sck_edge & (sck_lvl == cpol_q);
    sample_ev = cpha_q ? trail_ev : lead_ev;
    shift_ev  = cpha_q ? lead_ev  : trail_ev;

    // Active field moved to the top so it leaves MSB first.
    nbits   = clamp_bytes(32'(bus.byte_count), MAX_BYTES) * 8;
    aligned = tx_loaded_q ? (tx_word_q << (W - nbits)) : '0;

    unique case (state_q)
      IDLE: begin
        if (csel_fall) begin
          state_d       = ACTIVE;
          cpol_d        = bus.cpol;
          cpha_d        = bus.cpha;
          bit_cnt_d     = CW'(nbits - 1);
          rx_sh_d       = '0;
          tx_underrun_d = ~tx_loaded_q;
          tx_loaded_d   = 1'b0;
          if (bus.cpha) begin
            // First bit goes out on the first leading edge.
            tx_sh_d = aligned;
            miso_d  = 1'b0;
          end else begin
            // First bit must be on the line before the first leading edge.
            tx_sh_d = aligned << 1;
            miso_d  = aligned[W-1];
          end
        end else if (bus.tx_load) begin
          tx_word_d   = bus.tx_data;
          tx_loaded_d = 1'b1;
        end
      end
      ACTIVE: begin
        if (csel_rise) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
          miso_d    = 1'b0;
        end else begin
          if (shift_ev) begin
            miso_d  = tx_sh_q[W-1];
            tx_sh_d = tx_sh_q << 1;
          end
          if (sample_ev) begin
            rx_sh_d = {rx_sh_q[W-2:0], mosi_s};
            if (bit_cnt_q == '0) begin
              state_d    = DONE;
              rx_data_d  = rx_sh_d;
              rx_valid_d = 1'b1;
              miso_d     = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q - 1'b1;
            end
          end
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (csel_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The slave never drives data while deselected.
    if (csel_lvl) miso_d = 1'b0;
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mosi_sync_q   <= '0;
      state_q       <= IDLE;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      bit_cnt_q     <= '0;
      rx_sh_q       <= '0;
      tx_sh_q       <= '0;
      tx_word_q     <= '0;
      tx_loaded_q   <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      aborted_q     <= 1'b0;
      tx_underrun_q <= 1'b0;
      miso_q        <= 1'b0;
    end else begin
      mosi_sync_q   <= mosi_sync_d;
      state_q       <= state_d;
      cpol_q        <= cpol_d;
      cpha_q        <= cpha_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sh_q       <= rx_sh_d;
      tx_sh_q       <= tx_sh_d;
      tx_word_q     <= tx_word_d;
      tx_loaded_q   <= tx_loaded_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      aborted_q     <= aborted_d;
      tx_underrun_q <= tx_underrun_d;
      miso_q        <= miso_d;
    end
  end

  assign bus.MISO        = miso_q;
  assign bus.tx_loaded   = tx_loaded_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.aborted     = aborted_q;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_spi_slave_xfer.sv
// Bench for spi_slave_xfer: acts as SPI master, compares received words,
// MISO streams and status strobes against a frame-level reference model.
module tb_spi_slave_xfer;
  import spi_slave_pkg::*;

  localparam int MB   = 16;
  localparam int SS   = 3;
  localparam int W    = MB * 8;
  localparam int BC_W = $clog2(MB + 1);
  localparam int HALF = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_xfer_if #(.MAX_BYTES(MB)) bus ();

  spi_slave_xfer #(.MAX_BYTES(MB), .SYNC_STAGES(SS)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int           n_cmp = 0;
  int           n_bad = 0;
  int           rxv_cnt = 0;
  int           abt_cnt = 0;
  int           und_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [W-1:0] miso_cap;

  // Monitor: count strobes and collect every delivered word.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rxv_cnt++;
      obs_q.push_back(bus.rx_data);
    end
    if (bus.aborted === 1'b1) abt_cnt++;
    if (bus.tx_underrun === 1'b1) und_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got,
                          input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int eff_bits(input int bc);
    if (bc == 0 || bc > MB) return MB * 8;
    return bc * 8;
  endfunction

  function automatic logic [W-1:0] field_mask(input int nbits);
    logic [W-1:0] one;
    one = 1;
    if (nbits >= W) return '1;
    return (one << nbits) - one;
  endfunction

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [W-1:0] v);
    bus.tx_data = v;
    bus.tx_load = 1'b1;
    wait_clk(1);
    bus.tx_load = 1'b0;
    wait_clk(1);
  endtask

  task automatic frame_start(input logic [1:0] mode, input int bc);
    bus.SCK        = mode[1];
    bus.cpol       = mode[1];
    bus.cpha       = mode[0];
    bus.byte_count = BC_W'(bc);
    wait_clk(HALF);
    bus.CSEL = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic frame_clock(input int n, input logic [W-1:0] mosi_w,
                             input int nbits);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = (i < nbits) ? mosi_w[nbits-1-i] : 1'b1;
      if (!bus.cpha) begin
        bus.MOSI = b;
        wait_clk(HALF);
        if (i < nbits) miso_cap = {miso_cap[W-2:0], bus.MISO};
        bus.SCK = ~bus.cpol;
        wait_clk(HALF);
        bus.SCK = bus.cpol;
      end else begin
        bus.SCK  = ~bus.cpol;
        bus.MOSI = b;
        wait_clk(HALF);
        if (i < nbits) miso_cap = {miso_cap[W-2:0], bus.MISO};
        bus.SCK = bus.cpol;
        wait_clk(HALF);
      end
    end
  endtask

  task automatic frame_end();
    wait_clk(HALF);
    bus.CSEL = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic sb_drain(input string tag);
    check_eq({tag, "_rxn"}, W'(obs_q.size()), W'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check_eq({tag, "_rx"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  // A complete frame with every expectation derived from the model.
  task automatic full_frame(input logic [1:0] mode, input int bc,
                            input bit do_load, input logic [W-1:0] tx,
                            input logic [W-1:0] mosi, input int extra,
                            input string tag);
    int           nbits;
    int           rxv0, und0;
    logic [W-1:0] mask;
    nbits = eff_bits(bc);
    mask  = field_mask(nbits);
    if (do_load) load_tx(tx);
    rxv0     = rxv_cnt;
    und0     = und_cnt;
    miso_cap = '0;
    frame_start(mode, bc);
    check_eq({tag, "_txl_clr"}, W'(bus.tx_loaded), W'(0));
    // A load while busy must not arm the next frame.
    bus.tx_data = rand_word();
    bus.tx_load = 1'b1;
    wait_clk(1);
    bus.tx_load = 1'b0;
    frame_clock(nbits + extra, mosi, nbits);
    check_eq({tag, "_busy_done"}, W'(bus.busy), W'(1));
    frame_end();
    exp_q.push_back(mosi & mask);
    check_eq({tag, "_miso"}, miso_cap, do_load ? (tx & mask) : '0);
    check_eq({tag, "_nvalid"}, W'(rxv_cnt - rxv0), W'(1));
    check_eq({tag, "_nunder"}, W'(und_cnt - und0), W'(do_load ? 0 : 1));
    check_eq({tag, "_txl_after"}, W'(bus.tx_loaded), W'(0));
    check_eq({tag, "_busy_idle"}, W'(bus.busy), W'(0));
    sb_drain(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int           rxv0, abt0;
    logic [1:0]   mode;
    int           bc;
    bit           ld;
    logic [W-1:0] pattern;

    bus.SCK = 1'b0; bus.MOSI = 1'b0; bus.CSEL = 1'b1;
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.byte_count = '0;
    bus.tx_data = '0; bus.tx_load = 1'b0;

    wait_clk(4);
    check_eq("rst_busy", W'(bus.busy), W'(0));
    check_eq("rst_miso", W'(bus.MISO), W'(0));
    check_eq("rst_txl", W'(bus.tx_loaded), W'(0));
    check_eq("rst_rxdata", bus.rx_data, '0);
    check_eq("rst_strobes", W'({bus.rx_valid, bus.aborted, bus.tx_underrun}), W'(0));
    rst_n = 1'b1;
    wait_clk(6);

    // Mode 0, two bytes.
    full_frame(MODE0, 2, 1'b1, W'(16'h3C96), W'(16'hA55A), 0, "m0");

    // Mode 3, one byte.
    full_frame(MODE3, 1, 1'b1, W'(8'h81), W'(8'h7E), 0, "m3");
    check_eq("m3_hold", bus.rx_data, W'(8'h7E));

    // Mode 1, aborted after five bits.
    load_tx(rand_word());
    rxv0 = rxv_cnt;
    abt0 = abt_cnt;
    frame_start(MODE1, 2);
    frame_clock(5, W'(16'hFFFF), 16);
    check_eq("abort_busy_mid", W'(bus.busy), W'(1));
    frame_end();
    check_eq("abort_pulse", W'(abt_cnt - abt0), W'(1));
    check_eq("abort_novalid", W'(rxv_cnt - rxv0), W'(0));
    check_eq("abort_rxhold", bus.rx_data, W'(8'h7E));
    check_eq("abort_busy", W'(bus.busy), W'(0));

    // byte_count 0 clamps to the full buffer; extra clocks are ignored.
    pattern = 128'h0123456789abcdef_0123456789abcdef;
    full_frame(MODE2, 0, 1'b1, rand_word(), pattern, 3, "clamp");
    check_eq("clamp_hold", bus.rx_data, pattern);

    // No word loaded: underrun, zeros out, receive unaffected.
    full_frame(MODE1, 3, 1'b0, '0, rand_word(), 0, "underrun");

    // Reset in the middle of a frame.
    load_tx(W'(16'hBEEF));
    frame_start(MODE0, 2);
    frame_clock(9, W'(16'h1234), 16);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_busy", W'(bus.busy), W'(0));
    check_eq("mrst_miso", W'(bus.MISO), W'(0));
    check_eq("mrst_txl", W'(bus.tx_loaded), W'(0));
    check_eq("mrst_rxdata", bus.rx_data, '0);
    bus.CSEL = 1'b1;
    bus.SCK  = 1'b0;
    wait_clk(8);
    rst_n = 1'b1;
    wait_clk(8);
    obs_q.delete();
    // The pending word was dropped, so this frame is an underrun.
    full_frame(MODE0, 2, 1'b0, '0, W'(16'h5AA5), 0, "post_rst");

    // Randomized frames, sometimes with an overwritten pending word.
    for (int k = 0; k < 8; k++) begin
      mode = 2'($urandom_range(0, 3));
      bc   = int'($urandom_range(1, 4));
      ld   = 1'($urandom_range(0, 1));
      if (ld && $urandom_range(0, 1) == 1) load_tx(rand_word());
      full_frame(mode, bc, ld, rand_word(), rand_word(), 0, $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
